spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_master.sv | 120 ++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock divider.
// The state encoding is exported so that the top and any debug logic agree on it.
package spi_pkg;

  localparam int DIV_W_DEFAULT = 8;

  // Eight bits take sixteen SCK edges.
  localparam int EDGES_PER_BYTE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Issues one tick every div+1 cycles while en is high.
// The count restarts from zero whenever en drops or a tick fires.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_80,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  assign tick = en && (cnt_reg == div);

  always_ff @(posedge clk_80) begin
    if (rst || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master.
// Chip select stays low across bytes until a byte marked last has been sent and held.
module spi_master
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_80,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_last,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic             spi_sck,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n
);

  spi_state_e       state_reg, state_next;
  logic [DIV_W-1:0] div_reg;
  logic             last_reg;
  logic [7:0]       tx_reg;
  logic [7:0]       rx_reg;
  logic [7:0]       rsp_data_reg;
  logic [3:0]       edge_cnt_reg;
  logic             sck_reg;
  logic             mosi_reg;
  logic             rsp_valid_reg;
  logic             tick;
  logic             accept;
  logic             div_en;
  logic             frame_done;

  assign accept     = cmd_valid && cmd_ready;
  // The divider also times the post-frame hold; it restarts on the last SCK edge.
  assign div_en     = (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);
  assign frame_done = (state_reg == ST_SHIFT) && tick &&
                      (edge_cnt_reg == 4'(EDGES_PER_BYTE - 1));

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk_80(clk_80),
    .rst   (rst),
    .en    (div_en),
    .div   (div_reg),
    .tick  (tick)
  );

  always_ff @(posedge clk_80) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_WAIT: if (cmd_valid) state_next = ST_SHIFT;
      ST_SHIFT:         if (frame_done) state_next = last_reg ? ST_HOLD : ST_WAIT;
      ST_HOLD:          if (tick) state_next = ST_IDLE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
    spi_cs_n  = (state_reg == ST_IDLE);
    busy      = (state_reg != ST_IDLE);
  end

  always_ff @(posedge clk_80) begin
    if (rst) begin
      div_reg       <= '0;
      last_reg      <= 1'b0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      rsp_data_reg  <= '0;
      edge_cnt_reg  <= '0;
      sck_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      if (accept) begin
        div_reg      <= div;
        last_reg     <= cmd_last;
        tx_reg       <= cmd_data;
        mosi_reg     <= cmd_data[7];
        edge_cnt_reg <= '0;
      end else if ((state_reg == ST_SHIFT) && tick) begin
        sck_reg      <= ~sck_reg;
        edge_cnt_reg <= edge_cnt_reg + 4'd1;
        if (!sck_reg) begin
          rx_reg <= {rx_reg[6:0], spi_miso};
        end else if (!frame_done) begin
          tx_reg   <= {tx_reg[6:0], 1'b0};
          mosi_reg <= tx_reg[6];
        end
        if (frame_done) begin
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= rx_reg;
        end
      end
    end
  end

  assign spi_sck   = sck_reg;
  assign spi_mosi  = mosi_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: expected bytes are queued at command time and
// compared when rsp_valid pulses; a negedge monitor gathers SCK/CS timing.
module tb_spi_master;
  import spi_pkg::*;

  localparam int DIV_W = DIV_W_DEFAULT;
  localparam int TMO   = 2000;

  logic             clk_80 = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] div;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic             cmd_last;
  logic             rsp_valid;
  logic [7:0]       rsp_data;
  logic             busy;
  logic             spi_sck;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_cs_n;
  logic             miso_tie = 1'b0;

  always #5 clk_80 = ~clk_80;

  assign spi_miso = miso_tie ? 1'b1 : spi_mosi;

  spi_master #(.DIV_W(DIV_W)) dut (
    .clk_80   (clk_80),
    .rst      (rst),
    .div      (div),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_last (cmd_last),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int exp_hp = 0;  // expected SCK high-phase length; 0 means don't care
  logic [7:0] exp_q[$];

  // Monitor state, written only by the monitor process.
  int edge_total = 0;
  int rise_total = 0;
  int hi_run = 0;
  int hp_bad = 0;
  int cs_low_cnt = 0;
  int last_cs_low = 0;
  int cs_rise_total = 0;
  int rsp_total = 0;
  int viol_total = 0;
  logic sck_prev = 1'b0;

  always @(negedge clk_80) begin
    if (spi_sck !== sck_prev) begin
      edge_total <= edge_total + 1;
      if (spi_sck === 1'b1) rise_total <= rise_total + 1;
    end
    if (spi_sck === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0 && exp_hp != 0 && hi_run != exp_hp) hp_bad <= hp_bad + 1;
      hi_run <= 0;
    end
    if (spi_cs_n === 1'b0) begin
      cs_low_cnt <= cs_low_cnt + 1;
    end else begin
      if (cs_low_cnt != 0) begin
        last_cs_low   <= cs_low_cnt;
        cs_rise_total <= cs_rise_total + 1;
      end
      cs_low_cnt <= 0;
    end
    if (rsp_valid === 1'b1) rsp_total <= rsp_total + 1;
    if (busy !== ~spi_cs_n || (spi_cs_n === 1'b1 && (spi_sck !== 1'b0 || cmd_ready !== 1'b1)))
      viol_total <= viol_total + 1;
    sck_prev <= spi_sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [DIV_W-1:0] dv,
                      input bit push);
    int n = 0;
    cmd_data  = d;
    cmd_last  = l;
    div       = dv;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < TMO) begin
      @(posedge clk_80); #1;
      n++;
    end
    check("send_ready", 32'(n < TMO), 1);
    if (push) exp_q.push_back(miso_tie ? 8'hFF : d);
    @(posedge clk_80); #1;
    cmd_valid = 1'b0;
    $display("cmd   data=0x%02h last=%0d div=%0d", d, l, dv);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    logic [7:0] exp;
    while (rsp_valid !== 1'b1 && n < TMO) begin
      @(negedge clk_80); #1;
      n++;
    end
    check({tag, "_rsp_timeout"}, 32'(n < TMO), 1);
    if (n < TMO) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      popped++;
      $display("rsp   data=0x%02h expected=0x%02h", rsp_data, exp);
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
      @(negedge clk_80); #1;
      check({tag, "_rsp_pulse"}, 32'(rsp_valid), 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (spi_cs_n !== 1'b1 && n < TMO) begin
      @(negedge clk_80); #1;
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < TMO), 1);
  endtask

  int r0, c0, h0, e0, q0, n;

  initial begin
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_last  = 1'b0;
    div       = '0;
    repeat (3) @(posedge clk_80);
    @(negedge clk_80); #1;
    check("rst_cs_n", 32'(spi_cs_n), 1);
    check("rst_sck", 32'(spi_sck), 0);
    check("rst_mosi", 32'(spi_mosi), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk_80); #1;
    rst = 1'b0;
    @(negedge clk_80); #1;
    check("ready_after_rst", 32'(cmd_ready), 1);

    // Loopback at full rate
    exp_hp = 1; r0 = rise_total; c0 = cs_rise_total; h0 = hp_bad;
    send(8'hA5, 1'b1, 0, 1'b1);
    wait_rsp("t1");
    wait_idle("t1");
    check("t1_cs_low", 32'(last_cs_low), 17);
    check("t1_rises", 32'(rise_total - r0), 8);
    check("t1_cs_rises", 32'(cs_rise_total - c0), 1);
    check("t1_hp_bad", 32'(hp_bad - h0), 0);
    check("t1_mosi_hold", 32'(spi_mosi), 1);
    check("t1_rsp_held", 32'(rsp_data), 32'h A5);

    // MISO tied high, div=3
    miso_tie = 1'b1; exp_hp = 4; r0 = rise_total; h0 = hp_bad;
    send(8'h00, 1'b1, 3, 1'b1);
    wait_rsp("t2");
    wait_idle("t2");
    check("t2_cs_low", 32'(last_cs_low), 68);
    check("t2_rises", 32'(rise_total - r0), 8);
    check("t2_hp_bad", 32'(hp_bad - h0), 0);
    check("t2_mosi_hold", 32'(spi_mosi), 0);
    miso_tie = 1'b0;

    // Two-byte frame with an idle gap in WAIT
    exp_hp = 2; r0 = rise_total; c0 = cs_rise_total; h0 = hp_bad;
    send(8'h12, 1'b0, 1, 1'b1);
    wait_rsp("t3a");
    repeat (5) begin
      @(negedge clk_80); #1;
      check("t3_wait_cs_low", 32'(spi_cs_n), 0);
      check("t3_wait_sck_low", 32'(spi_sck), 0);
      check("t3_wait_ready", 32'(cmd_ready), 1);
    end
    send(8'h34, 1'b1, 1, 1'b1);
    wait_rsp("t3b");
    wait_idle("t3");
    check("t3_cs_rises", 32'(cs_rise_total - c0), 1);
    check("t3_rises", 32'(rise_total - r0), 16);
    check("t3_hp_bad", 32'(hp_bad - h0), 0);

    // Reset in the middle of a byte
    exp_hp = 0; e0 = edge_total; q0 = rsp_total;
    send(8'h5A, 1'b1, 3, 1'b0);
    n = 0;
    while (edge_total - e0 < 7 && n < TMO) begin
      @(negedge clk_80); #1;
      n++;
    end
    check("t4_edge_timeout", 32'(n < TMO), 1);
    check("t4_sck_high", 32'(spi_sck), 1);
    @(posedge clk_80); #1;
    rst = 1'b1;
    @(posedge clk_80); #1;
    rst = 1'b0;
    @(negedge clk_80); #1;
    check("t4_cs_n", 32'(spi_cs_n), 1);
    check("t4_sck", 32'(spi_sck), 0);
    check("t4_rsp_valid", 32'(rsp_valid), 0);
    check("t4_rsp_data", 32'(rsp_data), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_ready", 32'(cmd_ready), 1);
    repeat (40) @(negedge clk_80);
    #1;
    check("t4_no_rsp", 32'(rsp_total - q0), 0);
    exp_hp = 1;
    send(8'hC3, 1'b1, 0, 1'b1);
    wait_rsp("t4");
    wait_idle("t4");
    check("t4_cs_low", 32'(last_cs_low), 17);

    // Divider change during a byte takes effect only on the next byte
    exp_hp = 3; h0 = hp_bad; r0 = rise_total;
    send(8'h3C, 1'b0, 2, 1'b1);
    repeat (10) @(negedge clk_80);
    #1;
    div = 7;
    wait_rsp("t5a");
    exp_hp = 8;
    send(8'h96, 1'b1, 7, 1'b1);
    wait_rsp("t5b");
    wait_idle("t5");
    check("t5_hp_bad", 32'(hp_bad - h0), 0);
    check("t5_rises", 32'(rise_total - r0), 16);

    repeat (3) @(negedge clk_80);
    #1;
    check("invariants", 32'(viol_total), 0);
    check("rsp_count", 32'(rsp_total), 32'(popped));
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
